// File: rtl/csa_pipe_adder_if.sv
// Valid/ready operand and result bundle for the pipelined carry-skip adder.
// The master side drives operands and out_ready; the slave side is the adder.
interface csa_pipe_adder_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_BLK = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               sub;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               ovf;
  logic [NUM_BLK-1:0] skip_mask;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, skip_mask
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, skip_mask
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-skip adder/subtractor: BPS skip blocks of BLK bits per stage,
// global stall from the output handshake, last stage doubles as the output register.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int BPS   = 1
) (
  input logic             clk,
  input logic             rst_n,
  csa_pipe_adder_if.slave bus
);
  localparam int NUM_BLK = WIDTH / BLK;
  localparam int NUM_STG = NUM_BLK / BPS;
  localparam int SW      = BPS * BLK;
  localparam int LAST    = NUM_STG - 1;

  logic adv;

  logic               v_i   [NUM_STG];
  logic [WIDTH-1:0]   ax_i  [NUM_STG];
  logic [WIDTH-1:0]   bb_i  [NUM_STG];
  logic               c_i   [NUM_STG];
  logic [NUM_BLK-1:0] msk_i [NUM_STG];

  logic               v_q   [NUM_STG];
  logic [WIDTH-1:0]   ax_q  [NUM_STG];
  logic [WIDTH-1:0]   bb_q  [NUM_STG];
  logic               c_q   [NUM_STG];
  logic [NUM_BLK-1:0] msk_q [NUM_STG];
  logic               ovf_q;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ax shifts right by SW per stage with the fresh sum bits entering at the top,
  // so the next stage always works on the low SW bits and the last stage holds the
  // full sum. bb rotates so its MSB sits at SW-1 when the last stage needs it.
  for (genvar s = 0; s < NUM_STG; s++) begin : g_stg
    logic           c_o;
    logic           rc;
    logic           pp;
    logic           x;
    logic [SW-1:0]  sum_blk;
    logic [BPS-1:0] p_blk;

    if (s == 0) begin : g_src
      assign v_i[s]   = bus.in_valid;
      assign ax_i[s]  = bus.a;
      assign bb_i[s]  = bus.sub ? ~bus.b : bus.b;
      assign c_i[s]   = bus.sub | bus.cin;
      assign msk_i[s] = '0;
    end else begin : g_src
      assign v_i[s]   = v_q[s-1];
      assign ax_i[s]  = ax_q[s-1];
      assign bb_i[s]  = bb_q[s-1];
      assign c_i[s]   = c_q[s-1];
      assign msk_i[s] = msk_q[s-1];
    end

    always_comb begin
      c_o     = c_i[s];
      rc      = 1'b0;
      pp      = 1'b0;
      x       = 1'b0;
      sum_blk = '0;
      p_blk   = '0;
      for (int j = 0; j < BPS; j++) begin
        rc = c_o;
        pp = 1'b1;
        for (int k = 0; k < BLK; k++) begin
          x                = ax_i[s][j*BLK+k] ^ bb_i[s][j*BLK+k];
          sum_blk[j*BLK+k] = x ^ rc;
          rc               = (ax_i[s][j*BLK+k] & bb_i[s][j*BLK+k]) | (x & rc);
          pp               = pp & x;
        end
        p_blk[j] = pp;
        // skip mux: an all-propagate block forwards its incoming carry untouched
        c_o = pp ? c_o : rc;
      end
    end

    if (s < LAST) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q[s]   <= 1'b0;
          ax_q[s]  <= '0;
          bb_q[s]  <= '0;
          c_q[s]   <= 1'b0;
          msk_q[s] <= '0;
        end else if (adv) begin
          v_q[s]   <= v_i[s];
          ax_q[s]  <= (ax_i[s] >> SW) | (WIDTH'(sum_blk) << (WIDTH - SW));
          bb_q[s]  <= (bb_i[s] >> SW) | (bb_i[s] << (WIDTH - SW));
          c_q[s]   <= c_o;
          msk_q[s] <= msk_i[s] | (NUM_BLK'(p_blk) << (s * BPS));
        end
      end
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q[s]   <= 1'b0;
          ax_q[s]  <= '0;
          c_q[s]   <= 1'b0;
          msk_q[s] <= '0;
          ovf_q    <= 1'b0;
        end else if (adv) begin
          v_q[s]   <= v_i[s];
          ax_q[s]  <= (ax_i[s] >> SW) | (WIDTH'(sum_blk) << (WIDTH - SW));
          c_q[s]   <= c_o;
          msk_q[s] <= msk_i[s] | (NUM_BLK'(p_blk) << (s * BPS));
          ovf_q    <= (ax_i[s][SW-1] == bb_i[s][SW-1]) && (sum_blk[SW-1] != ax_i[s][SW-1]);
        end
      end
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = ax_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;
  assign bus.skip_mask = msk_q[LAST];
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed bench for csa_pipe_adder (WIDTH=16, BLK=4, BPS=1): reset, latency,
// carry-skip corner cases, stall/back-pressure ordering and mid-flight reset.
module tb_csa_pipe_adder;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  csa_pipe_adder_if #(.WIDTH(16), .NUM_BLK(4)) bus ();

  csa_pipe_adder #(.WIDTH(16), .BLK(4), .BPS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // {skip_mask, ovf, cout, sum} from plain integer arithmetic
  function automatic logic [21:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    logic [15:0] bb;
    logic [16:0] full;
    logic [3:0]  m;
    logic        o;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (s | c)};
    for (int i = 0; i < 4; i++) m[i] = &(a[4*i +: 4] ^ bb[4*i +: 4]);
    o = (a[15] == bb[15]) && (full[15] != a[15]);
    return {m, o, full[16], full[15:0]};
  endfunction

  task automatic send_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, input logic vc, input logic [15:0] es,
                          input logic ec, input logic eo, input logic [3:0] em);
    bus.a        = va;
    bus.b        = vb;
    bus.sub      = vs;
    bus.cin      = vc;
    bus.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.sum),       32'(es));
    chk({tag, "_cout"},  32'(bus.cout),      32'(ec));
    chk({tag, "_ovf"},   32'(bus.ovf),       32'(eo));
    chk({tag, "_mask"},  32'(bus.skip_mask), 32'(em));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] ra [8];
  logic [15:0] rb [8];
  logic        rs [8];
  logic        rc [8];
  logic [21:0] exq [$];
  logic [21:0] e;

  initial begin
    int sent, recv, stall_left, gaps, spurious;
    bit stalled_done;
    n_chk  = 0;
    n_fail = 0;

    // reset held over two edges with in_valid asserted
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'hFFFF;
    bus.b         = 16'h0001;
    bus.sub       = 1'b0;
    bus.cin       = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       32'(bus.sum),       32'd0);
    chk("rst_mask",      32'(bus.skip_mask), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("idle_no_output", 32'(bus.out_valid), 32'd0);
    end

    send_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110);
    send_one("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'b1110);
    send_one("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4'b0110);
    send_one("full_skip",  16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111);

    // eight back-to-back random transactions with a 3-cycle output stall
    for (int i = 0; i < 8; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rs[i] = 1'($urandom_range(0, 1));
      rc[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; recv = 0; stall_left = 0; gaps = 0; stalled_done = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      if (bus.out_valid && !stalled_done) begin
        stall_left   = 3;
        stalled_done = 1;
      end
      bus.out_ready = (stall_left == 0);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.a        = ra[sent];
        bus.b        = rb[sent];
        bus.sub      = rs[sent];
        bus.cin      = rc[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exq.push_back(model(ra[sent], rb[sent], rs[sent], rc[sent]));
        sent++;
      end
      if (stall_left > 0) begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_valid",    32'(bus.out_valid), 32'd1);
        if (exq.size() > 0) begin
          chk("stall_sum",  32'(bus.sum),       32'(exq[0][15:0]));
          chk("stall_mask", 32'(bus.skip_mask), 32'(exq[0][21:18]));
        end
        stall_left--;
      end else if (stalled_done && !bus.out_valid) begin
        gaps++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exq.size() == 0) begin
          chk("stream_unexpected", 32'd1, 32'd0);
        end else begin
          e = exq.pop_front();
          chk("stream_sum",  32'(bus.sum),       32'(e[15:0]));
          chk("stream_cout", 32'(bus.cout),      32'(e[16]));
          chk("stream_ovf",  32'(bus.ovf),       32'(e[17]));
          chk("stream_mask", 32'(bus.skip_mask), 32'(e[21:18]));
        end
        recv++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_recv",    32'(recv), 32'd8);
    chk("stream_sent",    32'(sent), 32'd8);
    chk("stream_gaps",    32'(gaps), 32'd0);
    chk("stream_stalled", 32'(stalled_done), 32'd1);
    chk("stream_left",    32'(exq.size()), 32'd0);

    // reset while three transactions are in flight
    for (int i = 0; i < 3; i++) begin
      bus.a        = 16'h1111 * 16'(i + 1);
      bus.b        = 16'h0101;
      bus.sub      = 1'b0;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    rst_n    = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) spurious++;
    end
    chk("midrst_discard", 32'(spurious), 32'd0);
    send_one("post_rst", 16'h0A5F, 16'h05A0, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 4'b0111);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined carry-skip adder/subtractor. It is the next generation of the team's combinational carry-skip adder building blocks.
- Operands are split into BLK-bit ripple blocks. Each block's group-propagate signal bypasses its carry chain, and BPS blocks are evaluated per pipeline stage.
- A valid/ready handshake on each side, with global stall, lets the block sit directly in a datapath with back-pressure.
- It also reports carry-out, signed overflow and a per-block skip mask for carry-path debug.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of BLK.
- BLK, 4, bits per carry-skip block; NUM_BLK = WIDTH/BLK.
- BPS, 1, skip blocks evaluated per pipeline stage; NUM_BLK must be a multiple of BPS. NUM_STG = NUM_BLK/BPS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands/controls valid.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  two's-complement overflow.
- skip_mask  out  NUM_BLK  bit i = 1 when block i had all-propagate, i.e. the skip path was taken.

Behaviour:
- Reset (rst_n=0 at an edge): all stage valid bits, sum, cout, ovf and skip_mask clear to 0. out_valid=0. in_ready=1 in the first cycle after reset is released. Reset mid-operation discards every in-flight transaction with no output.
- Stall: adv = !out_valid || out_ready. in_ready = adv, combinational, independent of in_valid.
- When adv=0, every stage register holds its contents.
- When adv=1, all stages shift by one, and stage 0 loads (in_valid, operands).
- Bubbles are carried as valid=0 and are not collapsed.
- Accept occurs when in_valid && in_ready at an edge.
- Operand preparation at accept: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage s (0..NUM_STG-1) evaluates blocks s*BPS .. s*BPS+BPS-1 from the carry registered by the previous stage (c0 for stage 0).
- Per block: p_i = &(a_blk ^ bb_blk). Sum bits come from a BLK-bit ripple. Carry out of the block = p_i ? carry_in : ripple_carry; an explicit mux is required.
- Each stage register holds: valid, the untouched upper operand bits, completed lower sum bits, the carry, the skip_mask bits so far, and a/bb MSBs for ovf.
- Latency: a transaction accepted at edge E0 (no stall) appears on the outputs with out_valid=1 immediately after edge E0+NUM_STG-1. With BPS=NUM_BLK the latency is 1 cycle.
- Each stall cycle adds exactly one cycle.
- The final stage is the output register. sum, cout, ovf and skip_mask are stable while out_valid && !out_ready.
- ovf = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
- cout is the raw final carry. For sub, cout=1 means no borrow.
- Throughput is 1 result per cycle when out_ready=1 continuously. Results are in strict acceptance order, with no loss or duplication.
- When out_valid=0, the output data fields may be stale. The bench checks them only when out_valid=1.

Test Plan:
(WIDTH=16, BLK=4, BPS=1 → NUM_STG=4)
1. Reset: hold rst_n=0 for 2 edges with in_valid=1 → out_valid=0, sum=0, skip_mask=0. After release, in_ready=1, and no spurious output for 8 cycles with in_valid=0.
2. a=0x7FFF, b=0x0001, sub=0, cin=0, accepted at edge t → out_valid=1 after edge t+3; sum=0x8000, cout=0, ovf=1, skip_mask=4'b0110.
3. a=0x0000, b=0x0001, sub=1 → sum=0xFFFF, cout=0, ovf=0, skip_mask=4'b1110. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
4. a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0, skip_mask=4'b1111 (carry travels entirely on the skip path).
5. Eight back-to-back random transactions; out_ready=0 for 3 cycles while out_valid=1 → in_ready=0 during the stall, output held stable, all 8 results match the reference model in order, with no gaps once out_ready=1.
6. Accept 3 transactions, then assert rst_n=0 for 1 edge → out_valid=0 next cycle; none of the 3 results ever appear. A new transaction then has normal 4-cycle latency and the correct result.
